// File: rtl/comb_controller.sv
`default_nettype none
// ============================================================================
//  Module      : comb_controller
//  Description : Computes the binomial coefficient C(n,k) by walking the
//                Pascal recursion iteratively with an external stack of
//                (n,k) frames. A base frame (k==0 or k==n) adds one to the
//                accumulator; any other frame pushes (n-1,k-1) and (n-1,k).
//                Frames are pushed n-then-k and popped k-then-n.
//  Ports       : clk, rst         - clock, asynchronous active-high reset
//                start,n_in,k_in  - request, sampled only while idle
//                busy,done,err    - status (done is a one-cycle pulse)
//                result           - C(n,k), held until the next accepted start
//                stk_push,stk_pop,stk_din - stack commands (from state only)
//                stk_dout,stk_empty       - stack read word and empty flag
//  Revision    : 1.0 - initial release
// ============================================================================
module comb_controller #(
    parameter int RES_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       n_in,
    input  logic [3:0]       k_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [RES_W-1:0] result,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [3:0]       stk_din,
    input  logic [3:0]       stk_dout,
    input  logic             stk_empty
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_PUSH_N = 4'd1,
        S_PUSH_K = 4'd2,
        S_CHECK  = 4'd3,
        S_GET_K  = 4'd4,
        S_GET_N  = 4'd5,
        S_EVAL   = 4'd6,
        S_P1N    = 4'd7,
        S_P1K    = 4'd8,
        S_P2N    = 4'd9,
        S_P2K    = 4'd10,
        S_DONE   = 4'd11
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_n;
    logic [3:0]       r_k;
    logic [3:0]       r_n_cur;
    logic [3:0]       r_k_cur;
    logic [RES_W-1:0] r_acc;
    logic [RES_W-1:0] r_result;
    logic             r_err;
    logic             w_base;

    assign w_base = (r_k_cur == 4'd0) || (r_k_cur == r_n_cur);

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_n      <= 4'd0;
            r_k      <= 4'd0;
            r_n_cur  <= 4'd0;
            r_k_cur  <= 4'd0;
            r_acc    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n   <= n_in;
                        r_k   <= k_in;
                        r_acc <= '0;
                        r_err <= (k_in > n_in);
                        if (k_in > n_in) begin
                            r_result <= '0;
                        end
                    end
                end
                S_CHECK: begin
                    // An empty stack means every frame has been evaluated.
                    if (stk_empty) begin
                        r_result <= r_acc;
                    end
                end
                // The stack registers its read word on the pop edge, so
                // each word is captured in the state after its pop.
                S_GET_K: r_k_cur <= stk_dout;
                S_GET_N: r_n_cur <= stk_dout;
                S_EVAL: begin
                    if (w_base) begin
                        r_acc <= r_acc + RES_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state and stack command decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_din  = 4'd0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (k_in > n_in) ? S_DONE : S_PUSH_N;
                end
            end
            S_PUSH_N: begin
                stk_push = 1'b1;
                stk_din  = r_n;
                w_next   = S_PUSH_K;
            end
            S_PUSH_K: begin
                stk_push = 1'b1;
                stk_din  = r_k;
                w_next   = S_CHECK;
            end
            S_CHECK: begin
                if (stk_empty) begin
                    w_next = S_DONE;
                end else begin
                    stk_pop = 1'b1;
                    w_next  = S_GET_K;
                end
            end
            S_GET_K: begin
                stk_pop = 1'b1;
                w_next  = S_GET_N;
            end
            S_GET_N: w_next = S_EVAL;
            S_EVAL:  w_next = w_base ? S_CHECK : S_P1N;
            // Non-base frames are never k==0, so k_cur-1 cannot wrap.
            S_P1N: begin
                stk_push = 1'b1;
                stk_din  = r_n_cur - 4'd1;
                w_next   = S_P1K;
            end
            S_P1K: begin
                stk_push = 1'b1;
                stk_din  = r_k_cur - 4'd1;
                w_next   = S_P2N;
            end
            S_P2N: begin
                stk_push = 1'b1;
                stk_din  = r_n_cur - 4'd1;
                w_next   = S_P2K;
            end
            S_P2K: begin
                stk_push = 1'b1;
                stk_din  = r_k_cur;
                w_next   = S_CHECK;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign err    = r_err;
    assign result = r_result;

endmodule
`default_nettype wire

// File: doc/comb_controller.md
COMB_CONTROLLER -- requirements
Module: comb_controller

Interface
REQ-001 The block SHALL have parameter RES_W, default 13, meaning result/accumulator width (covers C(15,7)=6435).
REQ-002 The block SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port start  input  1  request to compute C(n_in,k_in); sampled only in IDLE.
REQ-005 The block SHALL have ports n_in, k_in  input  4 each  operands, sampled with start.
REQ-006 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-007 The block SHALL have port done  output  1  one-cycle pulse in DONE state.
REQ-008 The block SHALL have port err  output  1  k_in>n_in on the last start; valid with done, held until next start.
REQ-009 The block SHALL have port result  output  RES_W  C(n,k); valid from done, held until next accepted start.
REQ-010 The block SHALL have ports stk_push, stk_pop  output  1 each  stack commands, never both high, combinational from state.
REQ-011 The block SHALL have port stk_din  output  4  word to push.
REQ-012 The block SHALL have port stk_dout  input  4  stack read word, registered by stack on pop edge, valid the cycle after pop.
REQ-013 The block SHALL have port stk_empty  input  1  stack empty flag, combinational from stack pointer.

Function
REQ-014 The block SHALL compute C(n,k) iteratively with an explicit stack of (n,k) frames: base frame (k==0 or k==n) adds 1 to acc; otherwise it pushes (n-1,k-1) then (n-1,k).
REQ-015 The block SHALL push each frame as n then k, and pop k then n.
REQ-016 IDLE: on start, the block SHALL latch n_in/k_in, clear acc and err; if k_in>n_in, set err, result=0, go DONE; else go PUSH_N.
REQ-017 PUSH_N SHALL drive stk_push=1, stk_din=n_reg, then go PUSH_K.
REQ-018 PUSH_K SHALL drive stk_push=1, stk_din=k_reg, then go CHECK.
REQ-019 CHECK: if stk_empty, the block SHALL load result=acc and go DONE; else stk_pop=1, go GET_K.
REQ-020 GET_K SHALL capture k_cur=stk_dout and drive stk_pop=1, then go GET_N.
REQ-021 GET_N SHALL capture n_cur=stk_dout, then go EVAL.
REQ-022 EVAL: for a base frame the block SHALL set acc=acc+1 and go CHECK; else go P1N.
REQ-023 P1N/P1K/P2N/P2K SHALL each push one word: n_cur-1, k_cur-1, n_cur-1, k_cur respectively, in that order, then go CHECK.
REQ-024 DONE SHALL assert done for exactly one cycle, then go IDLE.
REQ-025 The block SHALL ignore start when not in IDLE.
REQ-026 Latency from the edge sampling start to the edge entering DONE SHALL be 12*C(n,k)-5 cycles for valid operands, and 1 cycle for k>n.
REQ-027 acc SHALL be RES_W bits unsigned; no overflow occurs for n<=15.
REQ-028 The stack SHALL be empty at every accepted start (guaranteed because each run ends on stk_empty); the block SHALL not check this.
REQ-029 Peak stack occupancy SHALL not exceed 2*(n+1) words.

Reset
REQ-030 On rst the block SHALL enter IDLE immediately: busy=0, done=0, err=0, result=0, acc=0, stk_push=0, stk_pop=0, stk_din=0.
REQ-031 Reset mid-computation SHALL abandon the run with no done pulse; the stack shares rst and is cleared at the same time.
REQ-032 The first start after rst deassertion SHALL be accepted normally.

Verification
REQ-033 Scenario: start with n=3,k=3 -> done 7 cycles later, result=1, err=0; exactly 2 pushes and 2 pops.
REQ-034 Scenario: start with n=2,k=1 -> done after 19 cycles, result=2; stack empty at done.
REQ-035 Scenario: start with n=4,k=2 -> result=6 after 67 cycles; n=15,k=7 -> result=6435; sweep all n<=8, k<=n against a reference model.
REQ-036 Scenario: start with n=2,k=5 -> done next cycle, err=1, result=0, no stk_push/stk_pop.
REQ-037 Scenario: start pulses during busy -> ignored; result matches the first request only.
REQ-038 Scenario: rst asserted in EVAL of a C(6,3) run -> busy=0 asynchronously, no done; next start n=5,k=0 -> result=1.
